// File: rtl/piso_pkg.sv
// Shared types and constants for the PISO serializer and its bit counter.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam bit SHIFT_MSB_FIRST = 1'b1;
  localparam bit SHIFT_LSB_FIRST = 1'b0;

endpackage

// File: rtl/piso_bit_counter.sv
// Load / decrement / terminal-count counter; holds at zero instead of wrapping.
module piso_bit_counter #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          is_last
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CW'(WIDTH - 1);
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign is_last = (cnt_q == '0);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter with load handshake, stall and last-bit framing.
// Handshake: a word is taken on a rising edge where load_valid && load_ready;
// load_ready is combinational from shift_en so the next word lands on the last-bit cycle.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = SHIFT_MSB_FIRST,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             q_out,
  output logic             q_valid,
  output logic             last,
  output logic             busy
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic               q_out_q, q_out_d;
  logic               accept;
  logic               advance;
  logic               is_last;
  logic [$clog2(WIDTH)-1:0] cnt;

  function automatic logic out_bit(input logic [WIDTH-1:0] s);
    return (MSB_FIRST == SHIFT_LSB_FIRST) ? s[0] : s[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] s);
    return (MSB_FIRST == SHIFT_LSB_FIRST) ? {1'b0, s[WIDTH-1:1]} : {s[WIDTH-2:0], 1'b0};
  endfunction

  assign advance    = (state_q == SHIFT) && shift_en;
  assign load_ready = (state_q == IDLE) || (advance && is_last);
  assign accept     = load_valid && load_ready;

  piso_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .dec     (advance && !is_last),
    .cnt     (cnt),
    .is_last (is_last)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    if (accept) begin
      state_d = SHIFT;
      shreg_d = data_in;
    end else if (advance) begin
      if (is_last) begin
        state_d = IDLE;
      end else begin
        shreg_d = shift_once(shreg_q);
      end
    end
    // q_out is registered from the next-cycle view so it lines up with q_valid.
    q_out_d = (state_d == SHIFT) ? out_bit(shreg_d) : IDLE_LEVEL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      q_out_q <= IDLE_LEVEL;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      q_out_q <= q_out_d;
    end
  end

  assign q_out   = q_out_q;
  assign q_valid = (state_q == SHIFT);
  assign busy    = (state_q == SHIFT);
  assign last    = (state_q == SHIFT) && is_last && (cnt == '0);

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench: WIDTH=8 MSB-first table, WIDTH=4 MSB/LSB sequences, async reset mid-word.
module tb_piso_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=8, MSB first, idle 0
  logic [7:0] d8 = '0;
  logic lv8 = 1'b0, se8 = 1'b0;
  logic rdy8, q8, qv8, last8, busy8;
  // WIDTH=4, MSB first, idle 0
  logic [3:0] da = '0;
  logic lva = 1'b0, sea = 1'b0;
  logic rdya, qa, qva, lasta, busya;
  // WIDTH=4, LSB first, idle 1
  logic [3:0] db = '0;
  logic lvb = 1'b0, seb = 1'b0;
  logic rdyb, qb, qvb, lastb, busyb;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut8 (
    .clk(clk), .rst(rst), .data_in(d8), .load_valid(lv8), .load_ready(rdy8),
    .shift_en(se8), .q_out(q8), .q_valid(qv8), .last(last8), .busy(busy8));

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) duta (
    .clk(clk), .rst(rst), .data_in(da), .load_valid(lva), .load_ready(rdya),
    .shift_en(sea), .q_out(qa), .q_valid(qva), .last(lasta), .busy(busya));

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dutb (
    .clk(clk), .rst(rst), .data_in(db), .load_valid(lvb), .load_ready(rdyb),
    .shift_en(seb), .q_out(qb), .q_valid(qvb), .last(lastb), .busy(busyb));

  typedef struct {
    logic       lv;
    logic [7:0] d;
    logic       se;
    logic       q;
    logic       qv;
    logic       last;
    logic       rdy;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic lv, input logic [7:0] d, input logic se,
                     input logic q, input logic qv, input logic last, input logic rdy);
    vec_t v;
    v.lv = lv; v.d = d; v.se = se; v.q = q; v.qv = qv; v.last = last; v.rdy = rdy;
    tbl.push_back(v);
  endtask

  initial begin
    logic [3:0] wa;
    logic [7:0] bits;

    // Stall during 8'hA5 (10100101), ignored load while cnt!=0, stall on last bit.
    add(1, 8'hA5, 1, 0, 0, 0, 1);
    add(0, 8'h00, 1, 1, 1, 0, 0);
    add(0, 8'h00, 0, 0, 1, 0, 0);
    add(0, 8'h00, 0, 0, 1, 0, 0);
    add(0, 8'h00, 0, 0, 1, 0, 0);
    add(0, 8'h00, 1, 0, 1, 0, 0);
    add(0, 8'h00, 1, 1, 1, 0, 0);
    add(1, 8'h00, 1, 0, 1, 0, 0);
    add(0, 8'h00, 1, 0, 1, 0, 0);
    add(0, 8'h00, 1, 1, 1, 0, 0);
    add(0, 8'h00, 1, 0, 1, 0, 0);
    add(0, 8'h00, 0, 1, 1, 1, 0);
    add(0, 8'h00, 1, 1, 1, 1, 1);
    add(0, 8'h00, 1, 0, 0, 0, 1);
    // Back-to-back 8'hA5 then 8'h3C with load_valid held.
    add(1, 8'hA5, 1, 0, 0, 0, 1);
    bits = 8'hA5;
    for (int i = 0; i < 8; i++)
      add(1, (i == 7) ? 8'h3C : 8'hA5, 1, bits[7-i], 1, (i == 7), (i == 7));
    bits = 8'h3C;
    for (int i = 0; i < 8; i++)
      add(0, 8'h00, 1, bits[7-i], 1, (i == 7), (i == 7));
    add(0, 8'h00, 1, 0, 0, 0, 1);

    // Reset values.
    repeat (2) @(negedge clk);
    #1;
    check("rst q8", q8, 0);
    check("rst qv8", qv8, 0);
    check("rst qb idle", qb, 1);
    rst = 1'b0;

    // WIDTH=8 table.
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      lv8 = tbl[i].lv; d8 = tbl[i].d; se8 = tbl[i].se;
      #1;
      check($sformatf("v%0d q_out", i), q8, tbl[i].q);
      check($sformatf("v%0d q_valid", i), qv8, tbl[i].qv);
      check($sformatf("v%0d busy", i), busy8, tbl[i].qv);
      check($sformatf("v%0d last", i), last8, tbl[i].last);
      check($sformatf("v%0d load_ready", i), rdy8, tbl[i].rdy);
    end
    @(negedge clk);
    lv8 = 0; se8 = 0;

    // WIDTH=4: load 4'b1011 into the MSB-first and LSB-first instances.
    wa = 4'b1011;
    lva = 1; da = wa; sea = 1;
    lvb = 1; db = wa; seb = 1;
    #1;
    check("w4 msb ready", rdya, 1);
    check("w4 lsb idle q", qb, 1);
    @(negedge clk);
    lva = 0; lvb = 0;
    for (int i = 1; i <= 5; i++) begin
      #1;
      check($sformatf("w4 msb c%0d q", i), qa, (i <= 4) ? wa[4-i] : 1'b0);
      check($sformatf("w4 msb c%0d qv", i), qva, (i <= 4));
      check($sformatf("w4 msb c%0d last", i), lasta, (i == 4));
      check($sformatf("w4 lsb c%0d q", i), qb, (i <= 4) ? wa[i-1] : 1'b1);
      check($sformatf("w4 lsb c%0d qv", i), qvb, (i <= 4));
      check($sformatf("w4 lsb c%0d last", i), lastb, (i == 4));
      @(negedge clk);
    end

    // Reset mid-word after 3 bits of 8'h3C, then restart with 8'hFF.
    lv8 = 1; d8 = 8'h3C; se8 = 1;
    @(negedge clk);
    lv8 = 0;
    repeat (3) @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async rst q", q8, 0);
    check("async rst qv", qv8, 0);
    check("async rst last", last8, 0);
    check("async rst ready", rdy8, 1);
    @(negedge clk);
    rst = 1'b0;
    lv8 = 1; d8 = 8'hFF;
    #1;
    check("post rst ready", rdy8, 1);
    @(negedge clk);
    lv8 = 0;
    for (int i = 1; i <= 9; i++) begin
      if (i == 3) begin
        lv8 = 1; d8 = 8'h00;
      end else begin
        lv8 = 0;
      end
      #1;
      check($sformatf("ff c%0d q", i), q8, (i <= 8));
      check($sformatf("ff c%0d qv", i), qv8, (i <= 8));
      check($sformatf("ff c%0d last", i), last8, (i == 8));
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
